// File: rtl/decoders_pipe_if.sv
// Handshake bundle for the registered one-hot decoder stage.
// The master side is the environment; the slave side is the stage itself.
interface decoders_pipe_if #(
   parameter int AW = 2
);
   localparam int OW = 1 << AW;

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] A;
   logic          en;
   logic          scan_mode;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] Y;

   modport master (
      output in_valid, A, en, scan_mode, out_ready,
      input  in_ready, out_valid, Y
   );

   modport slave (
      input  in_valid, A, en, scan_mode, out_ready,
      output in_ready, out_valid, Y
   );
endinterface

// File: rtl/decoders_pipe.sv
// Registered binary-to-one-hot decoder behind a valid/ready stage with a
// one-entry skid, plus a walking-one scan source for one-hot consumer tests.
module decoders_pipe #(
   parameter int AW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   decoders_pipe_if.slave  bus
);
   localparam int OW = 2 ** AW;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_e;

   occ_e          state_q, state_d;
   logic [OW-1:0] y_q, y_d;
   logic [OW-1:0] skid_q, skid_d;
   logic          out_valid_q, out_valid_d;
   logic          rdy_q, rdy_d;
   logic [AW-1:0] scan_cnt_q, scan_cnt_d;

   logic          acc;
   logic          xfer;
   logic [AW-1:0] sel;
   logic          sel_en;
   logic [OW-1:0] beat;

   // rdy_q only reflects skid occupancy, so out_ready never reaches in_ready.
   assign bus.in_ready  = rdy_q & ~bus.scan_mode;
   assign bus.out_valid = out_valid_q;
   assign bus.Y         = y_q;

   always_comb begin
      // In scan mode the generator is the source and offers whenever there is room.
      acc    = rdy_q & (bus.scan_mode | bus.in_valid);
      xfer   = out_valid_q & bus.out_ready;
      sel    = bus.scan_mode ? scan_cnt_q : bus.A;
      sel_en = bus.scan_mode | bus.en;
      beat      = '0;
      beat[sel] = sel_en;

      state_d = state_q;
      y_d     = y_q;
      skid_d  = skid_q;

      case (state_q)
         S_EMPTY: begin
            if (acc) begin
               y_d     = beat;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (acc && xfer) begin
               y_d = beat;
            end else if (acc) begin
               skid_d  = beat;
               state_d = S_TWO;
            end else if (xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (xfer) begin
               y_d     = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase

      out_valid_d = (state_d != S_EMPTY);
      rdy_d       = (state_d != S_TWO);

      if (!bus.scan_mode)
         scan_cnt_d = '0;
      else if (acc)
         scan_cnt_d = scan_cnt_q + AW'(1);
      else
         scan_cnt_d = scan_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         y_q         <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         rdy_q       <= 1'b0;
         scan_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         rdy_q       <= rdy_d;
         scan_cnt_q  <= scan_cnt_d;
      end
   end
endmodule

// File: tb/tb_decoders_pipe.sv
// Randomized bench for decoders_pipe against a queue-based reference model.
module tb_decoders_pipe;
   localparam int AW = 2;
   localparam int OW = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   decoders_pipe_if #(.AW(AW)) bus ();

   decoders_pipe #(.AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: beats held by the stage, in order; head is what Y must show.
   logic [OW-1:0] q[$];
   int            cnt    = 0;
   bit            rdy_ok = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag);
      bit cap;
      cap = rdy_ok && (q.size() < 2);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(cap && !bus.scan_mode));
      if (q.size() > 0) chk({tag, ".Y"}, 32'(bus.Y), 32'(q[0]));
   endtask

   task automatic cyc(input string tag, input bit iv, input int a, input bit e,
                      input bit sm, input bit ordy);
      bit            cap;
      bit            acc;
      logic [OW-1:0] one;
      logic [OW-1:0] nb;
      @(negedge clk);
      check_outs(tag);
      bus.in_valid  = iv;
      bus.A         = AW'(a);
      bus.en        = e;
      bus.scan_mode = sm;
      bus.out_ready = ordy;
      one = 1;
      cap = rdy_ok && (q.size() < 2);
      acc = cap && (sm || iv);
      nb  = sm ? (one << cnt) : (e ? (one << a) : '0);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) begin
         q.push_back(nb);
         if (sm) cnt = (cnt + 1) % OW;
      end
      if (!sm) cnt = 0;
      rdy_ok = 1'b1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      check_outs(tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, ".rst_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".rst_Y"}, 32'(bus.Y), 32'd0);
      chk({tag, ".rst_in_ready"}, 32'(bus.in_ready), 32'd0);
      bus.in_valid  = 1'b0;
      bus.scan_mode = 1'b0;
      bus.out_ready = 1'b1;
      q.delete();
      cnt    = 0;
      rdy_ok = 1'b0;
      @(negedge clk);
      chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      rdy_ok = 1'b1;
   endtask

   initial begin
      bit sm;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.en        = 1'b0;
      bus.scan_mode = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset.Y", 32'(bus.Y), 32'd0);
      chk("reset.in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      rdy_ok = 1'b1;

      for (int i = 0; i < 4; i++) cyc("stream", 1'b1, i, 1'b1, 1'b0, 1'b1);
      cyc("stream_tail", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      cyc("en0", 1'b1, 2, 1'b0, 1'b0, 1'b1);
      cyc("en0_tail", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      cyc("bp1", 1'b1, 1, 1'b1, 1'b0, 1'b0);
      cyc("bp3", 1'b1, 3, 1'b1, 1'b0, 1'b0);
      cyc("bp_full", 1'b1, 0, 1'b1, 1'b0, 1'b0);
      cyc("bp_hold", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("bp_drain", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 7; i++) cyc("scan", 1'b0, 0, 1'b0, 1'b1, 1'b1);
      cyc("scan_off", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 3; i++) cyc("scan_bp", 1'b0, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc("scan_fall", 1'b1, 3, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc("scan_reenter", 1'b0, 0, 1'b0, 1'b1, 1'b1);
      cyc("scan_reenter_off", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      cyc("two1", 1'b1, 2, 1'b1, 1'b0, 1'b0);
      cyc("two2", 1'b1, 1, 1'b1, 1'b0, 1'b0);
      cyc("two3", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      do_reset("rst_two");
      for (int i = 0; i < 3; i++) cyc("post_rst", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      sm = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) sm = ~sm;
         cyc("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, OW - 1)),
             ($urandom_range(0, 4) != 0), sm, ($urandom_range(0, 9) < 7));
      end
      do_reset("rst_rand");
      cyc("final", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
